// File: rtl/lcd_reader_4bit.sv
// HD44780 4-bit read engine: busy-flag/address or data-RAM reads, returned through a req/done handshake.
// Optional poll mode repeats busy-flag reads until BF clears or POLL_MAX reads have been made.
module lcd_reader_4bit #(
    parameter int T_AS     = 4,
    parameter int T_EH     = 25,
    parameter int T_EL     = 25,
    parameter int T_H      = 2,
    parameter int POLL_MAX = 1000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       req_i,
    input  logic       req_rs_i,
    input  logic       req_poll_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       timeout_o,
    output logic [7:0] rd_data_o,
    output logic       busy_flag_o,
    output logic [6:0] addr_cnt_o,
    output logic       lcd_rs_o,
    output logic       lcd_rw_o,
    output logic       lcd_e_o,
    input  logic [3:0] lcd_d_in_i,
    output logic       lcd_bus_rel_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_EHI1, S_ELO1, S_EHI2, S_HOLD, S_GAP, S_FIN
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  phase_q, phase_d;
    logic [15:0] iter_q, iter_d;
    logic        rs_q, rs_d;
    logic        poll_q, poll_d;
    logic [3:0]  nib_hi_q, nib_hi_d;
    logic [3:0]  nib_lo_q, nib_lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        timeout_q, timeout_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        busy_flag_q, busy_flag_d;
    logic [6:0]  addr_cnt_q, addr_cnt_d;
    logic        lcd_rs_q, lcd_rs_d;
    logic        lcd_rw_q, lcd_rw_d;
    logic        lcd_e_q, lcd_e_d;
    logic        bus_rel_q, bus_rel_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            phase_q     <= '0;
            iter_q      <= '0;
            rs_q        <= 1'b0;
            poll_q      <= 1'b0;
            nib_hi_q    <= '0;
            nib_lo_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            rd_data_q   <= '0;
            busy_flag_q <= 1'b0;
            addr_cnt_q  <= '0;
            lcd_rs_q    <= 1'b0;
            lcd_rw_q    <= 1'b0;
            lcd_e_q     <= 1'b0;
            bus_rel_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            iter_q      <= iter_d;
            rs_q        <= rs_d;
            poll_q      <= poll_d;
            nib_hi_q    <= nib_hi_d;
            nib_lo_q    <= nib_lo_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            rd_data_q   <= rd_data_d;
            busy_flag_q <= busy_flag_d;
            addr_cnt_q  <= addr_cnt_d;
            lcd_rs_q    <= lcd_rs_d;
            lcd_rw_q    <= lcd_rw_d;
            lcd_e_q     <= lcd_e_d;
            bus_rel_q   <= bus_rel_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        iter_d      = iter_q;
        rs_d        = rs_q;
        poll_d      = poll_q;
        nib_hi_d    = nib_hi_q;
        nib_lo_d    = nib_lo_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        timeout_d   = timeout_q;
        rd_data_d   = rd_data_q;
        busy_flag_d = busy_flag_q;
        addr_cnt_d  = addr_cnt_q;
        lcd_rs_d    = lcd_rs_q;
        lcd_rw_d    = lcd_rw_q;
        lcd_e_d     = lcd_e_q;
        bus_rel_d   = bus_rel_q;

        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    rs_d      = req_rs_i;
                    poll_d    = req_poll_i & ~req_rs_i;
                    busy_d    = 1'b1;
                    lcd_rs_d  = req_rs_i;
                    lcd_rw_d  = 1'b1;
                    bus_rel_d = 1'b1;
                    iter_d    = '0;
                    phase_d   = 8'(T_AS - 1);
                    state_d   = S_SETUP;
                end
            end
            S_SETUP: begin
                if (phase_q == 8'd0) begin
                    lcd_e_d = 1'b1;
                    phase_d = 8'(T_EH - 1);
                    state_d = S_EHI1;
                end else begin
                    phase_d = phase_q - 8'd1;
                end
            end
            S_EHI1: begin
                // Nibble is taken in the last E-high cycle, the same edge E falls.
                if (phase_q == 8'd0) begin
                    nib_hi_d = lcd_d_in_i;
                    lcd_e_d  = 1'b0;
                    phase_d  = 8'(T_EL - 1);
                    state_d  = S_ELO1;
                end else begin
                    phase_d = phase_q - 8'd1;
                end
            end
            S_ELO1: begin
                if (phase_q == 8'd0) begin
                    lcd_e_d = 1'b1;
                    phase_d = 8'(T_EH - 1);
                    state_d = S_EHI2;
                end else begin
                    phase_d = phase_q - 8'd1;
                end
            end
            S_EHI2: begin
                if (phase_q == 8'd0) begin
                    nib_lo_d = lcd_d_in_i;
                    lcd_e_d  = 1'b0;
                    phase_d  = 8'(T_H - 1);
                    state_d  = S_HOLD;
                end else begin
                    phase_d = phase_q - 8'd1;
                end
            end
            S_HOLD: begin
                if (phase_q != 8'd0) begin
                    phase_d = phase_q - 8'd1;
                end else if (poll_q && nib_hi_q[3] && (iter_q < 16'(POLL_MAX - 1))) begin
                    phase_d = 8'(T_EL - 1);
                    state_d = S_GAP;
                end else begin
                    done_d      = 1'b1;
                    rd_data_d   = {nib_hi_q, nib_lo_q};
                    busy_flag_d = ~rs_q & nib_hi_q[3];
                    addr_cnt_d  = rs_q ? 7'd0 : {nib_hi_q[2:0], nib_lo_q};
                    timeout_d   = poll_q & nib_hi_q[3];
                    lcd_rw_d    = 1'b0;
                    lcd_rs_d    = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = S_FIN;
                end
            end
            S_GAP: begin
                // RS/RW never changed, so the next iteration strobes without a fresh setup.
                if (phase_q == 8'd0) begin
                    iter_d  = iter_q + 16'd1;
                    lcd_e_d = 1'b1;
                    phase_d = 8'(T_EH - 1);
                    state_d = S_EHI1;
                end else begin
                    phase_d = phase_q - 8'd1;
                end
            end
            S_FIN: begin
                bus_rel_d = 1'b0;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign timeout_o     = timeout_q;
    assign rd_data_o     = rd_data_q;
    assign busy_flag_o   = busy_flag_q;
    assign addr_cnt_o    = addr_cnt_q;
    assign lcd_rs_o      = lcd_rs_q;
    assign lcd_rw_o      = lcd_rw_q;
    assign lcd_e_o       = lcd_e_q;
    assign lcd_bus_rel_o = bus_rel_q;

endmodule

// File: tb/tb_lcd_reader_4bit.sv
// Scoreboard bench for lcd_reader_4bit: an LCD nibble model answers strobes, a monitor checks
// every done against results predicted from the byte sequence the LCD was given.
module tb_lcd_reader_4bit;

    localparam int T_AS     = 4;
    localparam int T_EH     = 25;
    localparam int T_EL     = 25;
    localparam int T_H      = 2;
    localparam int POLL_MAX = 4;
    localparam int LAT1     = T_AS + 2 * T_EH + T_EL + T_H;
    localparam int ITER     = 2 * T_EH + 2 * T_EL + T_H;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       req = 1'b0;
    logic       req_rs = 1'b0;
    logic       req_poll = 1'b0;
    logic [3:0] lcd_d = 4'd0;
    logic       busy_o, done_o, timeout_o, busy_flag_o;
    logic [7:0] rd_data_o;
    logic [6:0] addr_cnt_o;
    logic       lcd_rs, lcd_rw, lcd_e, lcd_bus_rel;

    lcd_reader_4bit #(
        .T_AS(T_AS), .T_EH(T_EH), .T_EL(T_EL), .T_H(T_H), .POLL_MAX(POLL_MAX)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .req_rs_i(req_rs), .req_poll_i(req_poll),
        .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o), .rd_data_o(rd_data_o),
        .busy_flag_o(busy_flag_o), .addr_cnt_o(addr_cnt_o), .lcd_rs_o(lcd_rs), .lcd_rw_o(lcd_rw),
        .lcd_e_o(lcd_e), .lcd_d_in_i(lcd_d), .lcd_bus_rel_o(lcd_bus_rel)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] rd;
        logic       bf;
        logic [6:0] addr;
        logic       to;
        int         cyc;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] nib_q[$];
    logic [7:0] pend[$];
    int         checks = 0;
    int         errors = 0;
    int         e_rise_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, want, $time);
        end
    endtask

    // LCD pad model plus output monitor; data is only meaningful while E is high.
    task automatic monitor();
        logic       e_prev = 1'b0;
        logic       done_prev = 1'b0;
        logic [7:0] last_rd = 8'd0;
        int         e_hi = 0;
        int         e_lo = 0;
        bit         seen_fall = 1'b0;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                e_prev = 1'b0; done_prev = 1'b0; last_rd = 8'd0;
                e_hi = 0; e_lo = 0; seen_fall = 1'b0;
                lcd_d = 4'($urandom);
            end else begin
                checks++;
                if (lcd_rw && !lcd_bus_rel) begin
                    errors++;
                    $display("FAIL bus_rel_while_rw actual=0 required=1 (t=%0t)", $time);
                end
                checks++;
                if (lcd_e && !lcd_rw) begin
                    errors++;
                    $display("FAIL rw_while_e actual=0 required=1 (t=%0t)", $time);
                end
                if (lcd_e && !e_prev) begin
                    e_rise_cnt++;
                    if (seen_fall) begin
                        checks++;
                        if (!(e_lo == T_EL || e_lo == T_H + T_EL)) begin
                            errors++;
                            $display("FAIL e_low_gap actual=%0d required=%0d or %0d", e_lo, T_EL, T_H + T_EL);
                        end
                    end
                    if (nib_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_strobe actual=1 required=0 (t=%0t)", $time);
                        lcd_d = 4'($urandom);
                    end else begin
                        lcd_d = nib_q.pop_front();
                    end
                    e_hi = 1;
                end else if (lcd_e) begin
                    e_hi++;
                end else begin
                    if (e_prev) begin
                        chk("e_high_width", e_hi, T_EH);
                        seen_fall = 1'b1;
                        e_lo = 1;
                    end else begin
                        e_lo++;
                    end
                    lcd_d = 4'($urandom);
                end
                if (!busy_o && !lcd_e) seen_fall = 1'b0;
                e_prev = lcd_e;

                if (done_prev) begin
                    chk("bus_rel_after_done", lcd_bus_rel, 0);
                    chk("done_width", done_o, 0);
                end
                if (done_o) begin
                    chk("bus_rel_in_done", lcd_bus_rel, 1);
                    chk("rw_in_done", lcd_rw, 0);
                    chk("busy_in_done", busy_o, 0);
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_done actual=1 required=0 (t=%0t)", $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rd_data", rd_data_o, e.rd);
                        chk("busy_flag", busy_flag_o, e.bf);
                        chk("addr_cnt", addr_cnt_o, e.addr);
                        chk("timeout", timeout_o, e.to);
                        chk("done_cycle", cyc, e.cyc);
                    end
                    last_rd = rd_data_o;
                end else begin
                    chk("rd_data_hold", rd_data_o, last_rd);
                end
                done_prev = done_o;
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy_o || done_o) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", busy_o | done_o, 0);
    endtask

    // Reference: the block keeps reading while BF=1 (poll only), at most POLL_MAX reads.
    task automatic do_txn(input logic rs, input logic poll, input bit in_done);
        int   reads, n;
        logic pe;
        exp_t e;
        if (in_done) begin
            n = 0;
            while (!done_o && n < 5000) begin
                @(negedge clk);
                n++;
            end
            chk("chain_done_seen", done_o, 1);
        end else begin
            wait_idle();
        end
        pe = poll & ~rs;
        reads = 1;
        while (pe && reads < POLL_MAX && pend[reads-1][7]) reads++;
        e.rd   = pend[reads-1];
        e.bf   = ~rs & e.rd[7];
        e.addr = rs ? 7'd0 : e.rd[6:0];
        e.to   = pe & e.rd[7];
        e.cyc  = cyc + 1 + (in_done ? 1 : 0) + LAT1 + (reads - 1) * ITER;
        for (int i = 0; i < reads; i++) begin
            nib_q.push_back(pend[i][7:4]);
            nib_q.push_back(pend[i][3:0]);
        end
        exp_q.push_back(e);
        $display("txn rs=%0d poll=%0d chained=%0d reads=%0d expect rd=0x%02h to=%0d",
                 rs, poll, in_done, reads, e.rd, e.to);
        req = 1'b1; req_rs = rs; req_poll = poll;
        @(negedge clk);
        if (in_done) begin
            chk("no_accept_in_done_cycle", busy_o, 0);
            @(negedge clk);
        end
        req = 1'b0; req_rs = 1'($urandom); req_poll = 1'($urandom);
        chk("busy_after_accept", busy_o, 1);
        n = 0;
        while (n < 20000) begin
            @(negedge clk);
            n++;
            if (done_o) break;
            req      = busy_o ? ($urandom_range(0, 5) == 0) : 1'b0;
            req_rs   = 1'($urandom);
            req_poll = 1'($urandom);
        end
        req = 1'b0;
        chk("done_within_bound", done_o, 1);
        pend.delete();
    endtask

    task automatic reset_mid_ehi2();
        int base, n;
        wait_idle();
        nib_q.push_back(4'($urandom));
        nib_q.push_back(4'($urandom));
        base = e_rise_cnt;
        $display("txn reset during second strobe");
        req = 1'b1; req_rs = 1'($urandom); req_poll = 1'b0;
        @(negedge clk);
        req = 1'b0;
        n = 0;
        while (e_rise_cnt < base + 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("second_strobe_reached", e_rise_cnt, base + 2);
        repeat (10) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_lcd_e", lcd_e, 0);
        chk("rst_lcd_rw", lcd_rw, 0);
        chk("rst_lcd_rs", lcd_rs, 0);
        chk("rst_bus_rel", lcd_bus_rel, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        nib_q.delete();
        @(negedge clk);
        chk("rst_rd_data", rd_data_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
    endtask

    initial begin
        int  nb;
        logic rs, poll;
        bit  chain;
        fork
            monitor();
        join_none
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy_o, 0);
        chk("reset_done", done_o, 0);
        chk("reset_timeout", timeout_o, 0);
        chk("reset_rd_data", rd_data_o, 0);
        chk("reset_busy_flag", busy_flag_o, 0);
        chk("reset_addr_cnt", addr_cnt_o, 0);
        chk("reset_lcd_e", lcd_e, 0);
        chk("reset_lcd_rw", lcd_rw, 0);
        chk("reset_lcd_rs", lcd_rs, 0);
        chk("reset_bus_rel", lcd_bus_rel, 0);
        rst_n = 1'b1;
        @(negedge clk);

        pend.push_back(8'h48);
        do_txn(1'b1, 1'b0, 1'b0);
        pend.push_back(8'h85);
        do_txn(1'b0, 1'b0, 1'b0);
        pend.push_back(8'h9A); pend.push_back(8'hC1); pend.push_back(8'hFF); pend.push_back(8'h03);
        do_txn(1'b0, 1'b1, 1'b0);
        pend.push_back(8'h80); pend.push_back(8'h81); pend.push_back(8'h82);
        pend.push_back(8'hA3); pend.push_back(8'hB4); pend.push_back(8'h05);
        do_txn(1'b0, 1'b1, 1'b0);
        pend.push_back(8'h27);
        do_txn(1'b0, 1'b1, 1'b1);
        pend.push_back(8'hDC);
        do_txn(1'b1, 1'b1, 1'b1);
        reset_mid_ehi2();
        pend.push_back(8'h3E);
        do_txn(1'b1, 1'b0, 1'b0);

        for (int t = 0; t < 24; t++) begin
            rs    = 1'($urandom);
            poll  = 1'($urandom);
            chain = ($urandom_range(0, 2) == 0);
            if (poll && !rs) begin
                nb = $urandom_range(0, 5);
                for (int i = 0; i < nb; i++) pend.push_back({1'b1, 7'($urandom)});
                pend.push_back({1'b0, 7'($urandom)});
            end else begin
                pend.push_back(8'($urandom));
            end
            do_txn(rs, poll, chain);
        end

        wait_idle();
        repeat (20) @(negedge clk);
        chk("expect_queue_drained", exp_q.size(), 0);
        chk("nibble_queue_drained", nib_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_reader_4bit.md
Name: lcd_reader_4bit

Overview:
- Performs HD44780 read transactions in 4-bit mode on the same 16x2 LCD bus that the board's LCD writer drives.
- Supports two reads: busy flag plus address counter (RS=0, RW=1) and data RAM (RS=1, RW=1).
- Each read is two enable strobes: high nibble first, then low nibble. The block assembles the byte and returns it through a req/done handshake.
- An optional poll mode repeats busy-flag reads until BF=0. This lets the writer sequence replace its fixed delays with real busy checks.

Parameters:
- T_AS, 4, cycles that RS/RW are stable before E rises (80 ns at 50 MHz; spec ≥40 ns)
- T_EH, 25, cycles E is high per nibble (500 ns; spec ≥450 ns, data valid ≤360 ns)
- T_EL, 25, cycles E is low between nibbles and between poll iterations
- T_H, 2, cycles RS/RW are held after the final E fall
- POLL_MAX, 1000, maximum busy-flag reads in one poll request before timeout
- All timing parameters are 1..255. POLL_MAX is 1..65535.

Ports:
- clk  in  1  board clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- req  in  1  start a read; sampled only in IDLE
- req_rs  in  1  0 = busy flag/address read, 1 = data RAM read; captured with req
- req_poll  in  1  1 = repeat busy read until BF=0; honoured only when req_rs=0
- busy  out  1  high from request acceptance until done
- done  out  1  one-cycle pulse when the result is valid
- timeout  out  1  qualifies done; 1 = poll gave up with BF still set
- rd_data  out  8  assembled byte {high nibble, low nibble}; holds until next done
- busy_flag  out  1  rd_data[7] when req_rs=0, else 0
- addr_cnt  out  7  rd_data[6:0] when req_rs=0, else 0
- lcd_rs  out  1  LCD register select
- lcd_rw  out  1  LCD read/write (1 = read)
- lcd_e  out  1  LCD enable
- lcd_d_in  in  4  LCD DATA[7:4] from the pad ({d7,d6,d5,d4})
- lcd_bus_rel  out  1  1 = top level must tristate FPGA drivers on DATA[7:4]

Behaviour:
- Reset (asynchronous, rst_n low):
  - State IDLE.
  - lcd_e=0, lcd_rw=0, lcd_rs=0, lcd_bus_rel=0.
  - busy=0, done=0, timeout=0, rd_data=0, busy_flag=0, addr_cnt=0.
  - Phase counter and poll counter cleared.
  - Reset mid-transaction aborts immediately. E drops asynchronously, and no done is issued.
- FSM states: IDLE, SETUP, EHI1, ELO1, EHI2, HOLD, GAP, FIN. An 8-bit phase counter counts each timed state down.
- IDLE:
  - On req=1 at edge 0: capture req_rs, and capture poll = req_poll & ~req_rs.
  - From edge 0: busy=1, lcd_rs=captured rs, lcd_rw=1, lcd_bus_rel=1. Go to SETUP.
- SETUP: T_AS cycles, then E rises; go to EHI1.
- EHI1: E high for T_EH cycles. The high nibble is lcd_d_in sampled in the last E-high cycle. E falls on that same edge; go to ELO1.
- ELO1: T_EL cycles, then E rises; go to EHI2.
- EHI2: as EHI1, capturing the low nibble; go to HOLD.
- HOLD: T_H cycles with E=0 and RS/RW unchanged. Then:
  - Poll and BF=1 and iterations < POLL_MAX: go to GAP.
  - Otherwise: go to FIN.
- GAP: T_EL cycles with E=0 and RW still 1. Increment the iteration count; go to EHI1. There is no new SETUP because RS/RW never changed.
- FIN:
  - Update rd_data, busy_flag and addr_cnt.
  - Pulse done for one cycle.
  - timeout = poll & BF.
  - lcd_rw=0, lcd_rs=0, busy=0.
  - lcd_bus_rel stays 1 this cycle and drops the next cycle, so the bus is released before RW goes high and re-driven only after RW is low.
  - Return to IDLE.
- Latency without poll: done is high in the cycle after edge T_AS+2·T_EH+T_EL+T_H. With defaults that is edge 81 (81 cycles after acceptance).
- Each poll iteration adds 2·T_EH+T_EL+T_H+T_EL cycles.
- E high is never shorter than T_EH. E low between strobes is never shorter than T_EL.
- Requests while busy are ignored. A request on the same cycle as done is not accepted; it is accepted the following cycle.
- The iteration counter is 16 bits. Reaching POLL_MAX forces FIN with timeout=1; there is no wrap-around.
- rd_data changes only at done.

Test Plan:
- Data read: req, req_rs=1; LCD model drives 0x4 then 0x8 -> after 81 cycles done=1, rd_data=0x48, busy_flag=0, addr_cnt=0. lcd_e high exactly 25 cycles, twice, with a 25-cycle low gap.
- Busy read: req_rs=0, model returns 0x8 then 0x5 -> rd_data=0x85, busy_flag=1, addr_cnt=0x05, timeout=0.
- Poll: req_poll=1, model BF=1 for 3 reads then 0x0,0x3 -> four E-pair iterations, single done, addr_cnt=0x03, timeout=0. Other requests are ignored throughout.
- Poll timeout: POLL_MAX=4, BF stuck at 1 -> done after the 4th read with timeout=1 and busy_flag=1.
- Reset mid-EHI2: rst_n low -> same cycle lcd_e=0, lcd_rw=0, lcd_bus_rel=0, busy=0, no done. Next req completes normally.
- Bus safety: assert for every cycle that lcd_rw=1 implies lcd_bus_rel=1, and lcd_e=1 implies lcd_rw=1. Also check that a req in the done cycle starts one cycle later.
